mod_round_gen: RTL and testbench



---
 rtl/mod_game_pkg.sv | 43 ++++
 rtl/mod_round_gen.sv | 132 +++++++++++++
 tb/tb_mod_round_gen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mod_game_pkg.sv
// ---------------------------------------------------------------------------
// mod_game_pkg
// Shared types and constants for the Modulus Game datapath.
//   round_state_t     : states of the round generator
//   game_val_t        : 7-bit unsigned game value (holds 0..99)
//   VAL_W / VAL_MAX   : width and top of the game value range
//   fallback_divisor  : divisor used when random sampling never hits
// ---------------------------------------------------------------------------
package mod_game_pkg;

    localparam int VAL_W   = 7;
    localparam int VAL_MAX = 99;

    typedef logic [VAL_W-1:0] game_val_t;

    typedef enum logic [2:0] {
        IDLE,
        PICK_A,
        PICK_B,
        REDUCE,
        DONE
    } round_state_t;

    // Deterministic divisor derived from the dividend so a round always
    // completes even if the random stream never lands in the legal range.
    // The result is clipped to the legal divisor range and the value range.
    function automatic game_val_t fallback_divisor(
        input game_val_t seed,
        input int        min_div,
        input int        max_div
    );
        int cand;
        cand = min_div + int'(seed[1:0]);
        if (cand > max_div) begin
            cand = max_div;
        end
        if (cand > VAL_MAX) begin
            cand = VAL_MAX;
        end
        return game_val_t'(cand);
    endfunction

endpackage

// File: rtl/mod_round_gen.sv
// ---------------------------------------------------------------------------
// mod_round_gen
// Builds one Modulus Game round from the 0..99 random stream: a dividend, a
// divisor in [MIN_DIV, MAX_DIV] and the answer (dividend mod divisor). The
// remainder is found by repeated subtraction, so no divider is needed.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   new_round      in   single-cycle request; ignored while busy
//   random_number  in   7-bit random value, 0..99, new value every clock
//   busy           out  round generation in progress
//   round_valid    out  dividend/divisor/answer valid until next accepted
//                       request
//   dividend       out  round dividend
//   divisor        out  round divisor
//   answer         out  dividend mod divisor
// ---------------------------------------------------------------------------
module mod_round_gen
    import mod_game_pkg::*;
#(
    parameter int MIN_DIV   = 2,
    parameter int MAX_DIV   = 12,
    parameter int MAX_RETRY = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_round,
    input  logic [VAL_W-1:0] random_number,
    output logic             busy,
    output logic             round_valid,
    output logic [VAL_W-1:0] dividend,
    output logic [VAL_W-1:0] divisor,
    output logic [VAL_W-1:0] answer
);

    // Wide enough to hold MAX_RETRY itself, and never zero bits wide.
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);

    round_state_t       state_q,    state_d;
    game_val_t          dividend_q, dividend_d;
    game_val_t          divisor_q,  divisor_d;
    game_val_t          answer_q,   answer_d;
    logic [RETRY_W-1:0] retry_q,    retry_d;

    logic               div_in_range;

    // The divisor candidate is legal when it lies inside the configured range.
    assign div_in_range = (random_number >= game_val_t'(MIN_DIV)) &&
                          (random_number <= game_val_t'(MAX_DIV));

    // Next-state and datapath. Every register holds by default; each state
    // only touches the fields it owns. The answer register doubles as the
    // running remainder during REDUCE.
    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        answer_d   = answer_q;
        retry_d    = retry_q;

        case (state_q)
            IDLE, DONE: begin
                if (new_round) begin
                    state_d = PICK_A;
                    retry_d = '0;
                end
            end

            PICK_A: begin
                dividend_d = random_number;
                answer_d   = random_number;
                state_d    = PICK_B;
            end

            PICK_B: begin
                // A hit on the last allowed sample still wins over the
                // fallback; only a miss with the budget spent falls back.
                if (div_in_range) begin
                    divisor_d = random_number;
                    state_d   = REDUCE;
                end else if (retry_q == RETRY_W'(MAX_RETRY)) begin
                    divisor_d = fallback_divisor(dividend_q, MIN_DIV, MAX_DIV);
                    state_d   = REDUCE;
                end else begin
                    retry_d = retry_q + RETRY_W'(1);
                end
            end

            REDUCE: begin
                // The >= guard rules out underflow in the 7-bit subtract.
                if (answer_q >= divisor_q) begin
                    answer_d = answer_q - divisor_q;
                end else begin
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset abandons any round in flight and
    // clears every visible value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            answer_q   <= '0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            answer_q   <= answer_d;
            retry_q    <= retry_d;
        end
    end

    // Status decodes straight from the state register, so busy and
    // round_valid are registered and mutually exclusive by construction.
    assign busy        = (state_q == PICK_A) || (state_q == PICK_B) ||
                         (state_q == REDUCE);
    assign round_valid = (state_q == DONE);
    assign dividend    = dividend_q;
    assign divisor     = divisor_q;
    assign answer      = answer_q;

endmodule

// File: tb/tb_mod_round_gen.sv
// ---------------------------------------------------------------------------
// tb_mod_round_gen
// Drives rounds into mod_round_gen and compares outputs and latency against
// a reference model built from plain arithmetic (%, /) over the sample
// stream the bench feeds in.
// ---------------------------------------------------------------------------
module tb_mod_round_gen;

    localparam int MIN_DIV   = 2;
    localparam int MAX_DIV   = 12;
    localparam int MAX_RETRY = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       newRound = 1'b0;
    logic [6:0] randomNumber = 7'd0;
    logic       busy;
    logic       roundValid;
    logic [6:0] dividend;
    logic [6:0] divisor;
    logic [6:0] answer;

    int checks = 0;
    int errors = 0;

    // Values presented on randomNumber: entry 0 in the PICK_A cycle,
    // entries 1.. in successive PICK_B cycles.
    logic [6:0] stimQ[$];

    mod_round_gen #(
        .MIN_DIV  (MIN_DIV),
        .MAX_DIV  (MAX_DIV),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .new_round    (newRound),
        .random_number(randomNumber),
        .busy         (busy),
        .round_valid  (roundValid),
        .dividend     (dividend),
        .divisor      (divisor),
        .answer       (answer)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Runs one round using stimQ. pulseAt > 0 re-pulses newRound in that
    // cycle (to be ignored); resetAt > 0 asserts rst in that cycle instead
    // of letting the round finish.
    task automatic applyStimulus(input int pulseAt, input int resetAt);
        int expDiv, expDvs, expAns, expLat, retries, k;
        bit done;

        while (stimQ.size() < MAX_RETRY + 2) begin
            stimQ.push_back(7'($urandom_range(0, 99)));
        end

        // Reference model: first in-range sample wins, else fallback.
        expDiv  = int'(stimQ[0]);
        expDvs  = -1;
        retries = MAX_RETRY;
        for (int i = 0; i <= MAX_RETRY; i++) begin
            if (expDvs < 0 && int'(stimQ[1+i]) >= MIN_DIV && int'(stimQ[1+i]) <= MAX_DIV) begin
                expDvs  = int'(stimQ[1+i]);
                retries = i;
            end
        end
        if (expDvs < 0) begin
            expDvs = MIN_DIV + (expDiv % 4);
            if (expDvs > MAX_DIV) expDvs = MAX_DIV;
        end
        expAns = expDiv % expDvs;
        expLat = 1 + (1 + retries) + (expDiv / expDvs + 1);

        @(negedge clk);
        newRound     = 1'b1;
        randomNumber = 7'($urandom_range(0, 99));

        k    = 1;
        done = 0;
        while (!done) begin
            @(negedge clk);
            newRound = (k == pulseAt);
            if (k == 1) begin
                checkOutput("acceptBusy", 32'(busy), 32'd1);
                checkOutput("acceptValidDrop", 32'(roundValid), 32'd0);
            end
            if (busy && roundValid) begin
                checkOutput("busyValidExclusive", 32'(busy & roundValid), 32'd0);
            end
            if (k == resetAt) begin
                rst = 1'b1;
                @(negedge clk);
                rst      = 1'b0;
                newRound = 1'b0;
                checkOutput("rstBusy", 32'(busy), 32'd0);
                checkOutput("rstValid", 32'(roundValid), 32'd0);
                checkOutput("rstDividend", 32'(dividend), 32'd0);
                checkOutput("rstDivisor", 32'(divisor), 32'd0);
                checkOutput("rstAnswer", 32'(answer), 32'd0);
                stimQ.delete();
                return;
            end
            if (roundValid) begin
                checkOutput("latency", 32'(k - 1), 32'(expLat));
                done = 1;
            end else if (k > 150) begin
                checkOutput("timeout", 32'(k - 1), 32'(expLat));
                done = 1;
            end else begin
                randomNumber = (k - 1 < stimQ.size()) ? stimQ[k-1]
                                                      : 7'($urandom_range(0, 99));
            end
            k++;
        end
        newRound = 1'b0;

        checkOutput("dividend", 32'(dividend), 32'(expDiv));
        checkOutput("divisor", 32'(divisor), 32'(expDvs));
        checkOutput("answer", 32'(answer), 32'(expAns));
        checkOutput("doneBusy", 32'(busy), 32'd0);

        // Without a request the finished round must hold.
        repeat (3) begin
            @(negedge clk);
            randomNumber = 7'($urandom_range(0, 99));
        end
        checkOutput("holdValid", 32'(roundValid), 32'd1);
        checkOutput("holdAnswer", 32'(answer), 32'(expAns));
        stimQ.delete();
    endtask

    // Directed rounds from the test plan, then randomized rounds.
    initial begin
        repeat (2) @(negedge clk);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetValid", 32'(roundValid), 32'd0);
        checkOutput("resetDividend", 32'(dividend), 32'd0);
        checkOutput("resetDivisor", 32'(divisor), 32'd0);
        checkOutput("resetAnswer", 32'(answer), 32'd0);
        rst = 1'b0;

        stimQ = '{7'd47, 7'd5};
        applyStimulus(0, 0);

        stimQ = '{7'd20, 7'd0, 7'd99, 7'd13, 7'd7};
        applyStimulus(0, 0);

        stimQ.push_back(7'd10);
        for (int i = 0; i <= MAX_RETRY; i++) stimQ.push_back(7'd50);
        applyStimulus(0, 0);

        stimQ = '{7'd0, 7'd12};
        applyStimulus(0, 0);

        stimQ = '{7'd99, 7'd2};
        applyStimulus(0, 0);

        // Request during REDUCE (cycle 3 with no retries) must be ignored.
        stimQ = '{7'd47, 7'd5};
        applyStimulus(3, 0);

        // Reset well inside REDUCE, then a fresh round.
        stimQ = '{7'd99, 7'd2};
        applyStimulus(0, 20);
        stimQ = '{7'd33, 7'd7};
        applyStimulus(0, 0);

        for (int r = 0; r < 25; r++) begin
            stimQ.push_back(7'($urandom_range(0, 99)));
            for (int i = 0; i <= MAX_RETRY; i++) begin
                if ($urandom_range(0, 3) == 0)
                    stimQ.push_back(7'($urandom_range(MIN_DIV, MAX_DIV)));
                else
                    stimQ.push_back(7'($urandom_range(0, 99)));
            end
            applyStimulus(0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
